// File: rtl/pipe_shifter_pkg.sv
// rtl/pipe_shifter_pkg.sv - shared shifter definitions: op encodings
package pipe_shifter_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

endpackage

// File: rtl/mux2.sv
// rtl/mux2.sv - generic 2:1 mux cell
module mux2 #(
  parameter int WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/pipe_shifter_shift_stage.sv
// rtl/pipe_shifter_shift_stage.sv - one combinational log-shifter level of fixed amount AMT
module shift_stage
  import pipe_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic [WIDTH-1:0] data,
  input  shift_op_e        op,
  input  logic             en,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] shifted;

  // Arithmetic shift keeps the MSB intact, so each level re-uses the current MSB as the sign fill.
  always_comb begin
    shifted = data;
    case (op)
      OP_SLL: shifted = data << AMT;
      OP_SRL: shifted = data >> AMT;
      OP_SRA: shifted = $signed(data) >>> AMT;
      OP_ROR: shifted = (data >> AMT) | (data << (WIDTH - AMT));
      default: shifted = data;
    endcase
  end

  mux2 #(.WIDTH(WIDTH)) u_mux (
    .sel (en),
    .a   (data),
    .b   (shifted),
    .y   (result)
  );

endmodule

// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - pipelined log shifter (SLL/SRL/SRA/ROR) with valid/ready and bubble collapse
module pipe_shifter
  import pipe_shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAGW  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag,
  output logic             busy
);

  logic [SHW-1:0]   vld_q;
  logic [WIDTH-1:0] data_q [SHW];
  logic [SHW-1:0]   sh_q   [SHW];
  shift_op_e        op_q   [SHW];
  logic [TAGW-1:0]  tag_q  [SHW];

  logic [SHW-1:0]   load;
  logic [SHW-1:0]   v_in;
  logic [WIDTH-1:0] d_in   [SHW];
  logic [WIDTH-1:0] d_out  [SHW];
  logic [SHW-1:0]   sh_in  [SHW];
  shift_op_e        op_in  [SHW];
  logic [TAGW-1:0]  tag_in [SHW];

  // A stage may load if any stage at or after it is empty, or the tail is draining.
  always_comb begin
    load = '0;
    for (int k = 0; k < SHW; k++) begin
      load[k] = out_ready;
      for (int j = k; j < SHW; j++) begin
        if (!vld_q[j]) load[k] = 1'b1;
      end
    end
  end

  always_comb begin
    v_in      = '0;
    v_in[0]   = in_valid;
    d_in[0]   = in_data;
    sh_in[0]  = in_shamt;
    op_in[0]  = shift_op_e'(in_op);
    tag_in[0] = in_tag;
    for (int k = 1; k < SHW; k++) begin
      v_in[k]   = vld_q[k-1];
      d_in[k]   = data_q[k-1];
      sh_in[k]  = sh_q[k-1];
      op_in[k]  = op_q[k-1];
      tag_in[k] = tag_q[k-1];
    end
  end

  // Shift amounts travel left-aligned: each stage consumes the MSB and drops it.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .AMT(1 << (SHW - 1 - k))) u_stage (
      .data   (d_in[k]),
      .op     (op_in[k]),
      .en     (sh_in[k][SHW-1]),
      .result (d_out[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
        sh_q[k]   <= '0;
        op_q[k]   <= OP_SLL;
        tag_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (flush)        vld_q[k] <= 1'b0;
        else if (load[k]) vld_q[k] <= v_in[k];
        if (load[k]) begin
          data_q[k] <= d_out[k];
          sh_q[k]   <= sh_in[k] << 1;
          op_q[k]   <= op_in[k];
          tag_q[k]  <= tag_in[k];
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_tag   = tag_q[SHW-1];
  assign busy      = |vld_q;

  logic unused_tail;
  assign unused_tail = ^{sh_q[SHW-1], op_q[SHW-1]};

endmodule

// File: tb/tb_pipe_shifter.sv
// tb/tb_pipe_shifter.sv - scoreboard bench for pipe_shifter
module tb_pipe_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        busy;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   rnd_on = 0;

  always #5 clk = ~clk;

  pipe_shifter #(.WIDTH(32), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Bit-at-a-time reference shifter.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < int'(s); i++) begin
      case (op)
        2'd0: r = {r[30:0], 1'b0};
        2'd1: r = {1'b0, r[31:1]};
        2'd2: r = {d[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", {28'd0, out_tag, out_data}, 64'hDEAD);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", {32'd0, out_data}, {32'd0, e.d});
            check("out_tag", {60'd0, out_tag}, {60'd0, e.t});
          end
        end
        if (in_valid && in_ready) sb.push_back('{d: model(in_op, in_data, in_shamt), t: in_tag});
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                      input logic [3:0] t, output int waits);
    bit ok;
    in_op = op; in_data = d; in_shamt = s; in_tag = t; in_valid = 1'b1;
    waits = 0;
    ok = 0;
    while (!ok && waits < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (!ok) waits++;
    end
    if (!ok) check("send_timeout", 64'(waits), 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1;
    end
    check("drain", {63'd0, done}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, n, acc, nout;
    logic [31:0] vd [8];
    logic [1:0]  vo [8];
    logic [4:0]  vs [8];
    vd = '{32'h80000000, 32'h80000000, 32'h12345678, 32'hA5A5F00F, 32'hA5A5F00F, 32'hA5A5F00F, 32'hA5A5F00F, 32'hFFFF0001};
    vo = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    vs = '{5'd4, 5'd4, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd16};

    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_out_tag", {60'd0, out_tag}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Latency: SLL 1 by 31
    check("model_sll31", {32'd0, model(2'd0, 32'h1, 5'd31)}, 64'h80000000);
    send(2'd0, 32'h1, 5'd31, 4'h5, w);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
    check("latency", 64'(n), 64'd5);
    wait_idle();

    // Directed vectors, back-to-back
    check("model_sra", {32'd0, model(2'd2, 32'h80000000, 5'd4)}, 64'hF8000000);
    check("model_ror", {32'd0, model(2'd3, 32'h12345678, 5'd8)}, 64'h78123456);
    for (int i = 0; i < 8; i++) send(vo[i], vd[i], vs[i], 4'(i), w);
    wait_idle();

    // Random ops under random backpressure
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 40; i++) send(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 4'(i), w);
    rnd_on = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_idle();

    // Fill with out_ready low, then release
    out_ready = 1'b0;
    acc = 0;
    in_op = 2'd0; in_shamt = 5'd3; in_tag = 4'd0; in_data = 32'd0; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
      in_tag = 4'(acc); in_data = 32'(acc) + 32'h100;
    end
    check("fill_accepted", 64'(acc), 64'd5);
    @(negedge clk);
    check("fill_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    nout = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (out_valid) nout++;
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
      if (acc >= 7) in_valid = 1'b0;
      else begin
        in_tag = 4'(acc); in_data = 32'(acc) + 32'h100;
      end
    end
    check("release_contig", 64'(nout), 64'd7);
    wait_idle();

    // Held result, collapse behind it
    out_ready = 1'b0;
    send(2'd3, 32'h12345678, 5'd8, 4'h9, w);
    check("hold_first_wait", 64'(w), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_data", {32'd0, out_data}, 64'h78123456);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 4; i++) begin
      send(2'd1, 32'hF0000000, 5'(i + 1), 4'(10 + i), w);
      check("collapse_wait", 64'(w), 64'd0);
    end
    @(negedge clk);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    // Flush with 3 in flight and an input offered
    for (int i = 0; i < 3; i++) send(2'd0, 32'h3, 5'(i), 4'(i), w);
    in_valid = 1'b1; in_data = 32'hBAD0BAD0; in_tag = 4'hF; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check("flush_busy", {63'd0, busy}, 64'd0);
    nout = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) nout++;
    end
    check("flush_no_out", 64'(nout), 64'd0);
    @(posedge clk);
    #1;

    // Async reset mid-stream
    for (int i = 0; i < 6; i++) send(2'd1, 32'hFF00FF00, 5'(i), 4'(i), w);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_out_data", {32'd0, out_data}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    sb.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(2'd2, 32'h40000000, 5'd30, 4'hA, w);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHW = log2(WIDTH) (5 at default) SHALL be derived, not set.
REQ-002 Parameter TAGW, default 4, width of the sideband tag carried alongside each operation.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 flush  in  1  synchronous discard of all in-flight operations.
REQ-006 in_valid  in  1  upstream offers an operation.
REQ-007 in_ready  out  1  pipe can accept this cycle.
REQ-008 in_data  in  WIDTH  operand.
REQ-009 in_shamt  in  SHW  shift amount, unsigned.
REQ-010 in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-011 in_tag  in  TAGW  sideband, returned unchanged with the result.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 out_data / out_tag  out  WIDTH / TAGW  result and its tag.
REQ-015 busy  out  1  high while any stage holds a valid operation.

Function
REQ-016 Log-shifter of SHW registered stages; stage k (k=0..SHW-1) SHALL shift by 2^(SHW-1-k) when shamt bit (SHW-1-k) is set, else pass data unchanged.
REQ-017 Each stage register SHALL hold valid, data, remaining shamt bits, op and tag.
REQ-018 SLL fills zeros at the LSB; SRL fills zeros at the MSB; SRA fills with the operand's original bit WIDTH-1; ROR wraps LSBs into the MSB.
REQ-019 shamt 0 SHALL return in_data unchanged for every op.
REQ-020 Transfer occurs on valid&ready on either port; no result SHALL be dropped, duplicated or reordered.
REQ-021 Latency: with out_ready held high, a result accepted in cycle N SHALL appear on out_valid in cycle N+SHW (5 at default); throughput one op per cycle.
REQ-022 Stage k SHALL load when it is empty or stage k+1 is loading in the same cycle (bubble collapse); in_ready = stage-0 load condition; final stage advances when out_ready=1.
REQ-023 With out_ready low, pipe SHALL fill to SHW entries, then deassert in_ready; out_data/out_tag SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 flush=1 SHALL clear every stage valid bit at the next edge; an input handshaking in the flush cycle SHALL be discarded; out_valid SHALL be 0 the cycle after flush.
REQ-025 flush and rst SHALL not alter in_ready's combinational definition; in_ready during flush follows REQ-022.
REQ-026 busy = OR of all stage valid bits.
REQ-027 No combinational path from in_valid to out_valid; in_ready MAY depend combinationally on out_ready.

Reset
REQ-028 rst SHALL asynchronously clear all valid bits, data, shamt, op and tag registers to 0.
REQ-029 During and after reset: out_valid=0, out_data=0, out_tag=0, busy=0, in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations; no result emerges for them after deassertion.

Structure
REQ-031 Op encodings (SLL/SRL/SRA/ROR) SHALL live in the team's shared shifter definitions header, reused by the decoder.
REQ-032 One sub-module, shift_stage (parameters WIDTH, AMT), SHALL implement one combinational shift level built from the existing 2:1 mux cell; pipe_shifter instantiates SHW of them plus stage registers.

Verification
REQ-033 SLL 0x00000001 shamt 31, out_ready=1 -> out_data 0x80000000 exactly 5 cycles after acceptance, tag preserved.
REQ-034 SRA 0x80000000 shamt 4 -> 0xF8000000; SRL same -> 0x08000000; ROR 0x12345678 shamt 8 -> 0x78123456; any op shamt 0 -> unchanged.
REQ-035 out_ready=0, issue 7 back-to-back ops tags 0..6 -> exactly 5 accepted, in_ready=0; release out_ready -> tags 0..6 emerge in order, one per cycle, none lost.
REQ-036 Single op then idle with out_ready=0 for 10 cycles -> result held stable; new op issued meanwhile collapses behind it, in_ready stays 1 until 5 entries held.
REQ-037 3 ops in flight, flush pulse with in_valid=1 -> next cycle out_valid=0, busy=0; flushed-cycle input never appears.
REQ-038 rst asserted asynchronously mid-stream (between edges) -> out_valid and busy drop immediately; after release first output is the first post-reset op.
